mod_p25519_reduce: RTL and testbench
====================================

MOD_P25519_REDUCE -- requirements
Module: mod_p25519_reduce

Interface
REQ-001 SHALL have parameter IN_W, default 512, input operand width; legal range 256..512.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operand.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_data  input  IN_W  unsigned operand T.
REQ-008 SHALL have port in_tag  input  TAG_W  sideband tag for the operand.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_data  output  255  reduced result.
REQ-012 SHALL have port out_tag  output  TAG_W  tag of the operand that produced out_data.
REQ-013 SHALL have port out_folds  output  2  number of non-trivial fold steps the result needed.

Function
REQ-014 SHALL reduce T modulo q = 2^255-19 using the identity 2^255 = 19 (mod q).
REQ-015 SHALL use a four-state FSM: IDLE, FOLD, SUB, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE.
REQ-017 SHALL, on in_valid&&in_ready at an edge, load T, in_tag and fold count 0, and enter FOLD.
REQ-018 SHALL, in FOLD with T[IN_W-1:255]!=0, replace T with T[254:0] + 19*T[IN_W-1:255], increment the fold count, and stay in FOLD.
REQ-019 SHALL, in FOLD with T[IN_W-1:255]==0, go to SUB when MODQ_CANON_EN is defined, else to DONE.
REQ-020 SHALL, in SUB, set T = T-q when T>=q, otherwise leave T unchanged, then go to DONE.
REQ-021 SHALL size the internal fold datapath so no carry is lost for any IN_W; the fold count never exceeds 3 (worst case at IN_W=512).
REQ-022 SHALL drive out_valid=1 only in DONE, with out_data=T[254:0], out_tag and out_folds taken from registers.
REQ-023 SHALL hold out_data, out_tag and out_folds stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on out_valid&&out_ready, return to IDLE, so the next operand is accepted no earlier than the following edge.
REQ-025 SHALL raise out_valid exactly folds+2 edges after the accept edge with MODQ_CANON_EN, and folds+1 edges without it.
REQ-026 SHALL ignore in_data and in_tag whenever in_ready=0.

Reset
REQ-027 SHALL, while rst=1 (asynchronously, at any state including mid-FOLD or DONE), force IDLE and clear T, the tag and the fold count to 0.
REQ-028 SHALL drive, during reset, out_valid=0, in_ready=1, out_data=0, out_tag=0 and out_folds=0.
REQ-029 SHALL discard any in-flight operand on reset and produce no result for it.

Configuration
REQ-030 SHALL use macro MODQ_CANON_EN to select the output form:
- defined: SUB state present; out_data is canonical, in the range 0..q-1.
- undefined: SUB state absent; out_data is weakly reduced, below 2^255 but possibly in the range q..2^255-1, and latency is one edge shorter.

Verification
REQ-031 SHALL cover IN_W=512, in_data=2^512-1, in_tag=5 -> out_data=1443, out_folds=3, out_tag=5, out_valid 5 edges after accept (CANON).
REQ-032 SHALL cover in_data=2^255-19 -> out_data=0 with CANON, out_data=2^255-19 without it; out_folds=0; latency 2 or 1 respectively.
REQ-033 SHALL cover in_data=2^255 -> out_data=19, out_folds=1; and in_data=0 -> out_data=0, out_folds=0.
REQ-034 SHALL cover in_data=2^255-1 -> out_data=18 with CANON, out_data=2^255-1 without it.
REQ-035 SHALL cover out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge, next operand accepted.
REQ-036 SHALL cover rst pulsed during FOLD of 2^512-1 -> out_valid=0 and in_ready=1 immediately; a following operand 2^255+5 -> out_data=24.

Source files
------------

// File: rtl/mod_p25519_reduce.sv
// mod_p25519_reduce: reduces an IN_W-bit operand modulo q = 2^255-19.
// The reduction repeatedly folds the bits above 2^255 back in as
// T[254:0] + 19*T[IN_W-1:255].
// Optional macro MODQ_CANON_EN adds a final conditional subtract of q,
// which makes the result canonical (0..q-1). Without it, the result is
// weakly reduced (below 2^255).
module mod_p25519_reduce #(
  parameter int unsigned IN_W  = 512,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [254:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_folds
);

  localparam int unsigned HI_W = IN_W - 255;

`ifdef MODQ_CANON_EN
  localparam logic [254:0] Q = {{250{1'b1}}, 5'b01101};
  typedef enum logic [1:0] {S_IDLE, S_FOLD, S_SUB, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FOLD, S_DONE} state_t;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [IN_W-1:0]    r_t;
  logic [TAG_W-1:0]   r_tag;
  logic [1:0]         r_folds;

  logic [IN_W-1:0]    w_lo;
  logic [IN_W-1:0]    w_hi;
  logic [IN_W-1:0]    w_fold;
  logic               w_hi_nz;
`ifdef MODQ_CANON_EN
  logic               w_ge_q;
  logic [254:0]       w_sub;
`endif

  // The fold sum is below 2^max(255,HI_W+5)+1, which never exceeds 2^IN_W
  // for IN_W >= 256. That lets the fold reuse the operand width with no carry lost.
  assign w_lo    = {{HI_W{1'b0}}, r_t[254:0]};
  assign w_hi    = {{255{1'b0}}, r_t[IN_W-1:255]};
  assign w_fold  = w_lo + (w_hi << 4) + (w_hi << 1) + w_hi;
  assign w_hi_nz = |r_t[IN_W-1:255];

`ifdef MODQ_CANON_EN
  // The operand is already below 2^255 here, so one subtract of q is enough.
  assign w_ge_q = (r_t[254:0] >= Q);
  assign w_sub  = r_t[254:0] - Q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_FOLD;
      S_FOLD: begin
        if (!w_hi_nz) begin
`ifdef MODQ_CANON_EN
          w_next = S_SUB;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef MODQ_CANON_EN
      S_SUB:  w_next = S_DONE;
`endif
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand, tag and fold-count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t     <= '0;
      r_tag   <= '0;
      r_folds <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_t     <= in_data;
            r_tag   <= in_tag;
            r_folds <= '0;
          end
        end
        S_FOLD: begin
          if (w_hi_nz) begin
            r_t     <= w_fold;
            r_folds <= r_folds + 2'd1;
          end
        end
`ifdef MODQ_CANON_EN
        S_SUB: begin
          if (w_ge_q) r_t <= {{HI_W{1'b0}}, w_sub};
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_t[254:0];
  assign out_tag   = r_tag;
  assign out_folds = r_folds;

endmodule

// File: tb/tb_mod_p25519_reduce.sv
// Self-checking bench for mod_p25519_reduce (IN_W=512, TAG_W=4).
// Follows MODQ_CANON_EN the same way the design does.
module tb_mod_p25519_reduce;

  localparam int unsigned IN_W  = 512;
  localparam int unsigned TAG_W = 4;
`ifdef MODQ_CANON_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [254:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_folds;

  int n_vec = 0;
  int n_err = 0;

  mod_p25519_reduce #(.IN_W(IN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_folds(out_folds)
  );

  always #5 clk = ~clk;

  // Reference model. The fold count comes from repeatedly applying
  // 2^255 = 19 (mod q). The canonical value is computed with a plain modulo.
  function automatic void model(input logic [511:0] d, output logic [254:0] r,
                                output int f);
    logic [519:0] t;
    logic [519:0] q;
    q = (520'd1 << 255) - 520'd19;
    t = {8'd0, d};
    f = 0;
    while ((t >> 255) != 520'd0) begin
      t = (t & ((520'd1 << 255) - 520'd1)) + 520'd19 * (t >> 255);
      f++;
    end
`ifdef MODQ_CANON_EN
    t = {8'd0, d} % q;
`endif
    r = t[254:0];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Offer one operand, then wait (bounded) for the result.
  // The result is left in DONE for the caller to release.
  task automatic run_op(input logic [511:0] d, input logic [3:0] tg,
                        output logic [254:0] od, output logic [3:0] ot,
                        output logic [1:0] of, output int lat, output bit to);
    in_valid = 1'b1; in_data = d; in_tag = tg;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = rand512(); in_tag = 4'($urandom);
    lat = 0; to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin to = 1'b0; break; end
    end
    od = out_data; ot = out_tag; of = out_folds;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_tag = '0;
    #23;
    n_vec++;
    if ({out_valid, in_ready, out_data, out_tag, out_folds} !== {1'b0, 1'b1, 255'd0, 4'd0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b rdy=%b d=%h tag=%h f=%0d, want v=0 rdy=1 d=0 tag=0 f=0",
               out_valid, in_ready, out_data, out_tag, out_folds);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_corners();
    logic [511:0] d [5];
    logic [254:0] ec [5];
    logic [254:0] ew [5];
    int           ef [5];
    logic [254:0] od, ed;
    logic [3:0]   ot;
    logic [1:0]   of;
    int           lat;
    bit           to;
    logic [254:0] q255;
    q255 = {{250{1'b1}}, 5'b01101};
    d[0] = '1;                                 ec[0] = 255'd1443; ew[0] = 255'd1443; ef[0] = 3;
    d[1] = {257'd0, q255};                     ec[1] = 255'd0;    ew[1] = q255;      ef[1] = 0;
    d[2] = 512'd1 << 255;                      ec[2] = 255'd19;   ew[2] = 255'd19;   ef[2] = 1;
    d[3] = '0;                                 ec[3] = 255'd0;    ew[3] = 255'd0;    ef[3] = 0;
    d[4] = (512'd1 << 255) - 512'd1;           ec[4] = 255'd18;   ew[4] = '1;        ef[4] = 0;
    for (int i = 0; i < 5; i++) begin
`ifdef MODQ_CANON_EN
      ed = ec[i];
`else
      ed = ew[i];
`endif
      run_op(d[i], (i == 0) ? 4'd5 : 4'(i), od, ot, of, lat, to);
      n_vec++;
      if (to) begin
        n_err++;
        $display("FAIL corner%0d_timeout: got no out_valid in 20 edges, want one after %0d", i, ef[i] + EXTRA);
      end else begin
        if (od !== ed || int'(of) != ef[i] || ot !== ((i == 0) ? 4'd5 : 4'(i)) || lat != ef[i] + EXTRA) begin
          n_err++;
          $display("FAIL corner%0d: got d=%h f=%0d tag=%0d lat=%0d, want d=%h f=%0d tag=%0d lat=%0d",
                   i, od, of, ot, lat, ed, ef[i], (i == 0) ? 5 : i, ef[i] + EXTRA);
        end
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [511:0] d;
    logic [254:0] od, ed;
    logic [3:0]   ot, tg;
    logic [1:0]   of;
    int           lat, ef;
    bit           to;
    for (int i = 0; i < 40; i++) begin
      d = rand512();
      case ($urandom_range(0, 4))
        0: ;
        1: d = d & ((512'd1 << 255) - 512'd1);
        2: d = (512'd1 << 255) - 512'd19 + 512'($urandom_range(0, 40)) - 512'd20;
        3: d = (512'd1 << 255) + 512'($urandom_range(0, 1000));
        default: d = d >> $urandom_range(0, 256);
      endcase
      tg = 4'($urandom);
      model(d, ed, ef);
      run_op(d, tg, od, ot, of, lat, to);
      n_vec++;
      if (to || od !== ed || int'(of) != ef || ot !== tg || lat != ef + EXTRA) begin
        n_err++;
        $display("FAIL random%0d: in=%h got d=%h f=%0d tag=%0d lat=%0d to=%b, want d=%h f=%0d tag=%0d lat=%0d",
                 i, d, od, of, ot, lat, to, ed, ef, tg, ef + EXTRA);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] d;
    logic [254:0] od, ed;
    logic [3:0]   ot;
    logic [1:0]   of;
    int           lat, ef;
    bit           to, bad;
    d = rand512();
    model(d, ed, ef);
    run_op(d, 4'd9, od, ot, of, lat, to);
    bad = to;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = rand512(); in_tag = 4'($urandom);
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_data !== ed || out_tag !== 4'd9 || int'(out_folds) != ef) bad = 1'b1;
    end
    in_valid = 1'b0;
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL backpressure_hold: got v=%b rdy=%b d=%h tag=%0d f=%0d, want v=1 rdy=0 d=%h tag=9 f=%0d",
               out_valid, in_ready, out_data, out_tag, out_folds, ed, ef);
    end
    release_out();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_release: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
    end
    d = (512'd1 << 300) + 512'd7;
    model(d, ed, ef);
    run_op(d, 4'd3, od, ot, of, lat, to);
    n_vec++;
    if (to || od !== ed || int'(of) != ef || ot !== 4'd3) begin
      n_err++;
      $display("FAIL backpressure_next: got d=%h f=%0d tag=%0d to=%b, want d=%h f=%0d tag=3",
               od, of, ot, to, ed, ef);
    end
    release_out();
  endtask

  task automatic test_reset_midfold();
    logic [254:0] od;
    logic [3:0]   ot;
    logic [1:0]   of;
    int           lat;
    bit           to, bad;
    in_valid = 1'b1; in_data = '1; in_tag = 4'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, in_ready, out_data, out_tag, out_folds} !== {1'b0, 1'b1, 255'd0, 4'd0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_midfold: got v=%b rdy=%b d=%h tag=%h f=%0d, want v=0 rdy=1 d=0 tag=0 f=0",
               out_valid, in_ready, out_data, out_tag, out_folds);
    end
    @(negedge clk); rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL reset_discard: got v=%b rdy=%b after reset, want v=0 rdy=1", out_valid, in_ready);
    end
    run_op((512'd1 << 255) + 512'd5, 4'd2, od, ot, of, lat, to);
    n_vec++;
    if (to || od !== 255'd24 || of !== 2'd1 || ot !== 4'd2 || lat != 1 + EXTRA) begin
      n_err++;
      $display("FAIL reset_next_op: got d=%h f=%0d tag=%0d lat=%0d to=%b, want d=24 f=1 tag=2 lat=%0d",
               od, of, ot, lat, to, 1 + EXTRA);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [511:0] d;
    logic [254:0] ed;
    int           ef, lat;
    bit           to;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = rand512() >> $urandom_range(0, 255);
      model(d, ed, ef);
      in_data = d; in_tag = 4'(i);
      @(posedge clk); #1;
      in_data = rand512(); in_tag = 4'($urandom);
      lat = 0; to = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        lat++;
        if (out_valid) begin to = 1'b0; break; end
      end
      n_vec++;
      if (to || out_data !== ed || int'(out_folds) != ef || out_tag !== 4'(i) || lat != ef + EXTRA) begin
        n_err++;
        $display("FAIL b2b%0d: got d=%h f=%0d tag=%0d lat=%0d to=%b, want d=%h f=%0d tag=%0d lat=%0d",
                 i, out_data, out_folds, out_tag, lat, to, ed, ef, i, ef + EXTRA);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_corners();
    test_random();
    test_backpressure();
    test_reset_midfold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
